systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Consumes the per-PE result bus of the systolic array core, which is skewed and arrives one valid bit per PE.
- Captures one complete ROWS x COLS result tile, then streams it out one element per transfer, row-major, over a valid/ready handshake.
- Sits between the array output and the writeback/DMA path. It is the reader for the array's result interface.

Parameters:
- DBITS, 8, operand width; each result element is 2*DBITS bits.
- ROWS, 2, PE rows in the array.
- COLS, 2, PE columns in the array.

Ports:
- i_CLK  input  1  clock.
- i_RSTN  input  1  asynchronous active-low reset.
- i_DATA  input  ROWS*COLS*2*DBITS  array results. Element (r,c) occupies slice index k = c*ROWS + r, bits [(k+1)*2*DBITS-1 : k*2*DBITS].
- i_VALID  input  ROWS*COLS  per-PE result valid, bit k = c*ROWS + r.
- o_DATA  output  2*DBITS  current streamed element.
- o_VALID  output  1  o_DATA valid.
- i_READY  input  1  downstream accepts; a transfer occurs when o_VALID & i_READY.
- o_ROW  output  max(1,$clog2(ROWS))  row index of current element.
- o_COL  output  max(1,$clog2(COLS))  column index of current element.
- o_LAST  output  1  current element is (ROWS-1, COLS-1).
- o_BUSY  output  1  state is DRAIN.
- o_OVERFLOW  output  1  sticky; a result pulse was dropped.
- i_CLR_OVF  input  1  synchronous clear of o_OVERFLOW.

Behaviour:
- Single clock. Reset is asynchronous and active-low.
- Reset state: state=COLLECT, all capture flags=0, buffer=0, row/col counters=0, o_OVERFLOW=0.
- Resulting outputs at reset: o_VALID=0, o_BUSY=0, o_LAST=0, o_DATA=0, o_ROW=0, o_COL=0.
- Storage: buffer of ROWS*COLS entries, each 2*DBITS wide, plus one capture flag per entry.

COLLECT state:
- For each k with i_VALID[k]=1 and flag[k]=0: buffer[k] <= i_DATA slice k; flag[k] <= 1.
- For each k with i_VALID[k]=1 and flag[k]=1: the value is dropped and o_OVERFLOW <= 1.
- When all flags are 1 at a clock edge (the set includes captures made in that same edge's cycle), the next state is DRAIN.
- Latency: the last capture is registered at edge t, and o_VALID=1 from the cycle following edge t.

DRAIN state:
- o_VALID=1 and o_BUSY=1.
- o_DATA = buffer[col*ROWS + row], driven combinationally from registers. o_ROW=row, o_COL=col.
- Order is row-major: col increments first. When col wraps COLS-1 -> 0, row increments.
- o_LAST=1 when row==ROWS-1 and col==COLS-1.
- o_VALID, o_DATA, o_ROW and o_COL are held stable while i_READY=0; there is no retraction.
- A transfer with o_LAST=1 does all of the following on the same edge: clears all flags, returns row/col to 0, and moves to COLLECT. o_VALID is 0 the next cycle.
- Any i_VALID bit = 1 during DRAIN, including the final-transfer cycle, is dropped and sets o_OVERFLOW. The buffer is never modified in DRAIN.

o_OVERFLOW:
- Set has priority over i_CLR_OVF in the same cycle.
- Cleared only by i_CLR_OVF or reset.

Reset mid-operation:
- Asynchronous reset during either state returns immediately to the reset values. A partial tile is discarded.

Degenerate sizes:
- ROWS=1 or COLS=1 is legal. The corresponding counter is pinned at 0, and the index width is 1.

Decomposition:
- Shared package (systolic_pkg):
  - localparams NUM_PE = ROWS*COLS, RES_W = 2*DBITS, ROW_W, COL_W.
  - state enum {COLLECT, DRAIN}.
  - index function pe_idx(r,c) = c*ROWS + r, also reused by the array core and its bench.
- Single module; no sub-module needed. The output mux is an inline indexed select.

Test Plan (DBITS=8, ROWS=2, COLS=2):
1. Simultaneous capture:
   - Stimulus: all 4 i_VALID high in one cycle, with (0,0)=16'h0001, (1,0)=16'h0002, (0,1)=16'h0003, (1,1)=16'h0004; i_READY held 1.
   - Required: o_VALID asserts the next cycle. Outputs are 0001, 0003, 0002, 0004 on 4 consecutive cycles; o_LAST only on 0004; o_VALID=0 afterwards.
2. Skewed arrival:
   - Stimulus: k=0 at cycle 0; k=1 and k=2 at cycle 1; k=3 at cycle 2.
   - Required: o_BUSY=0 through cycle 2, o_VALID=1 at cycle 3. Stream order and values match scenario 1.
3. Backpressure:
   - Stimulus: tile from scenario 1; i_READY toggles 0,0,1,0,1,1,1.
   - Required: o_DATA and o_ROW/o_COL are held stable during stalls. Exactly 4 transfers occur, in order 0001, 0003, 0002, 0004.
4. Overflow:
   - Stimulus: during DRAIN pulse i_VALID[2]=1 with 16'hBEEF; separately, in COLLECT pulse k=0 twice.
   - Required: o_OVERFLOW=1 in both cases; the streamed values are unchanged (no BEEF; the first k=0 value is kept). i_CLR_OVF clears it the next cycle.
5. Reset mid-drain:
   - Stimulus: assert i_RSTN=0 after 2 transfers.
   - Required: o_VALID=0 immediately (asynchronous). After release a fresh tile streams from (0,0).
6. Back-to-back tiles:
   - Stimulus: second tile's valids arrive the cycle after the first tile's o_LAST transfer.
   - Required: second tile is captured fully with no overflow and streams correctly.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path.
package systolic_pkg;

    // Default array configuration shared by the core, the drain and their benches.
    localparam int unsigned P_DBITS = 8;
    localparam int unsigned P_ROWS  = 2;
    localparam int unsigned P_COLS  = 2;

    localparam int unsigned NUM_PE = P_ROWS * P_COLS;
    localparam int unsigned RES_W  = 2 * P_DBITS;
    localparam int unsigned ROW_W  = (P_ROWS > 1) ? $clog2(P_ROWS) : 1;
    localparam int unsigned COL_W  = (P_COLS > 1) ? $clog2(P_COLS) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    // Flat PE index: the array lays its results out column-major.
    function automatic int unsigned pe_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned rows = P_ROWS);
        return c * rows + r;
    endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Captures one skewed ROWS x COLS result tile and streams it out row-major.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned DBITS = P_DBITS,
    parameter int unsigned ROWS  = P_ROWS,
    parameter int unsigned COLS  = P_COLS
) (
    input  logic                                           i_CLK,
    input  logic                                           i_RSTN,
    input  logic [ROWS*COLS*2*DBITS-1:0]                   i_DATA,
    input  logic [ROWS*COLS-1:0]                           i_VALID,
    output logic [2*DBITS-1:0]                             o_DATA,
    output logic                                           o_VALID,
    input  logic                                           i_READY,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]     o_ROW,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]     o_COL,
    output logic                                           o_LAST,
    output logic                                           o_BUSY,
    output logic                                           o_OVERFLOW,
    input  logic                                           i_CLR_OVF
);

    localparam int unsigned N_PE  = ROWS * COLS;
    localparam int unsigned R_W   = 2 * DBITS;
    localparam int unsigned RI_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CI_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned SEL_W = (N_PE > 1) ? $clog2(N_PE) : 1;

    state_e            state_q, state_d;
    logic [N_PE-1:0]   flag_q, flag_d;
    logic [R_W-1:0]    buf_q [N_PE];
    logic [R_W-1:0]    buf_d [N_PE];
    logic [RI_W-1:0]   row_q, row_d;
    logic [CI_W-1:0]   col_q, col_d;
    logic              ovf_q, ovf_d;
    logic              ovf_set;
    logic              drain_c;
    logic              last_c;
    logic [SEL_W-1:0]  sel_c;

    // Output decode straight from registered state.
    assign drain_c    = (state_q == DRAIN);
    assign last_c     = drain_c && (row_q == RI_W'(ROWS - 1)) && (col_q == CI_W'(COLS - 1));
    assign sel_c      = SEL_W'(pe_idx(32'(row_q), 32'(col_q), ROWS));
    assign o_DATA     = buf_q[sel_c];
    assign o_VALID    = drain_c;
    assign o_BUSY     = drain_c;
    assign o_LAST     = last_c;
    assign o_ROW      = row_q;
    assign o_COL      = col_q;
    assign o_OVERFLOW = ovf_q;

    // Next-state: capture per-PE results in COLLECT, walk the tile row-major in DRAIN.
    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        buf_d   = buf_q;
        row_d   = row_q;
        col_d   = col_q;
        ovf_set = 1'b0;
        unique case (state_q)
            COLLECT: begin
                for (int unsigned k = 0; k < N_PE; k++) begin
                    if (i_VALID[k]) begin
                        if (flag_q[k]) begin
                            ovf_set = 1'b1;
                        end else begin
                            flag_d[k] = 1'b1;
                            buf_d[k]  = i_DATA[k*R_W +: R_W];
                        end
                    end
                end
                if (&flag_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Results arriving while the buffer is owned by the stream are lost.
                if (|i_VALID) begin
                    ovf_set = 1'b1;
                end
                if (i_READY) begin
                    if (last_c) begin
                        state_d = COLLECT;
                        flag_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == CI_W'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + RI_W'(1);
                    end else begin
                        col_d = col_q + CI_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
        // A new drop wins over a clear in the same cycle.
        ovf_d = ovf_set | (ovf_q & ~i_CLR_OVF);
    end

    // State, capture buffer, counters and sticky overflow.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q <= COLLECT;
            flag_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < N_PE; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ovf_q   <= ovf_d;
            for (int unsigned k = 0; k < N_PE; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain with a tile-level reference model.
module tb_systolic_result_drain;

    localparam int unsigned R = 2;
    localparam int unsigned C = 2;
    localparam int unsigned N = R * C;
    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] data;
    logic [N-1:0]   vld;
    logic           rdy;
    logic           clr;
    logic [W-1:0]   o_data;
    logic           o_valid;
    logic [0:0]     o_row;
    logic [0:0]     o_col;
    logic           o_last;
    logic           o_busy;
    logic           o_ovf;

    systolic_result_drain #(.DBITS(8), .ROWS(2), .COLS(2)) dut (
        .i_CLK      (clk),
        .i_RSTN     (rst_n),
        .i_DATA     (data),
        .i_VALID    (vld),
        .o_DATA     (o_data),
        .o_VALID    (o_valid),
        .i_READY    (rdy),
        .o_ROW      (o_row),
        .o_COL      (o_col),
        .o_LAST     (o_last),
        .o_BUSY     (o_busy),
        .o_OVERFLOW (o_ovf),
        .i_CLR_OVF  (clr)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a tile of elements, which positions have arrived, and
    // the row-major position of the element currently offered downstream.
    logic [W-1:0] m_tile [R][C];
    bit           m_got  [R][C];
    bit           m_drain = 1'b0;
    int           m_pos   = 0;
    bit           m_ovf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit set;
        bit all;
        int k;
        if (!rst_n) begin
            m_drain = 1'b0;
            m_pos   = 0;
            m_ovf   = 1'b0;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    m_got[r][c] = 1'b0;
        end else begin
            set = 1'b0;
            if (!m_drain) begin
                all = 1'b1;
                for (int r = 0; r < R; r++) begin
                    for (int c = 0; c < C; c++) begin
                        k = c * R + r;
                        if (vld[k]) begin
                            if (m_got[r][c]) set = 1'b1;
                            else begin
                                m_got[r][c]  = 1'b1;
                                m_tile[r][c] = data[k*W +: W];
                            end
                        end
                        if (!m_got[r][c]) all = 1'b0;
                    end
                end
                if (all) begin
                    m_drain = 1'b1;
                    m_pos   = 0;
                end
            end else begin
                if (|vld) set = 1'b1;
                if (rdy) begin
                    if (m_pos == N - 1) begin
                        m_drain = 1'b0;
                        for (int r = 0; r < R; r++)
                            for (int c = 0; c < C; c++)
                                m_got[r][c] = 1'b0;
                    end else begin
                        m_pos++;
                    end
                end
            end
            if (set) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    end

    // Per-cycle compare against the model, plus a log of accepted elements.
    logic [W-1:0] log_q [$];

    always @(negedge clk) begin
        int r;
        int c;
        if (rst_n) begin
            chk("o_VALID", 32'(o_valid), 32'(m_drain));
            chk("o_BUSY", 32'(o_busy), 32'(m_drain));
            chk("o_OVERFLOW", 32'(o_ovf), 32'(m_ovf));
            if (m_drain) begin
                r = m_pos / C;
                c = m_pos % C;
                chk("o_DATA", 32'(o_data), 32'(m_tile[r][c]));
                chk("o_ROW", 32'(o_row), 32'(r));
                chk("o_COL", 32'(o_col), 32'(c));
                chk("o_LAST", 32'(o_last), 32'(m_pos == N - 1));
            end else begin
                chk("o_LAST_idle", 32'(o_last), 32'd0);
            end
            if (o_valid && rdy) log_q.push_back(o_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present all four results in one cycle; argument order is k = 0..3.
    task automatic load_tile(input logic [W-1:0] k0, input logic [W-1:0] k1,
                             input logic [W-1:0] k2, input logic [W-1:0] k3);
        data = {k3, k2, k1, k0};
        vld  = 4'hF;
        tick();
        vld  = 4'h0;
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (log_q.size() < n && t < 100) begin
            tick();
            t++;
        end
        chk("xfer_count", 32'(log_q.size()), 32'(n));
    endtask

    task automatic chk_stream(input string name, input int base,
                              input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] exp [4];
        logic [W-1:0] act;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) begin
            act = (base + i < log_q.size()) ? log_q[base + i] : 'x;
            chk(name, 32'(act), 32'(exp[i]));
        end
    endtask

    initial begin
        int base;
        logic [0:0] pat [7];
        rst_n = 1'b0;
        data  = '0;
        vld   = '0;
        rdy   = 1'b0;
        clr   = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_row", 32'(o_row), 32'd0);
        chk("rst_col", 32'(o_col), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        #20;
        rst_n = 1'b1;
        tick();

        // 1: simultaneous capture, ready held high
        rdy  = 1'b1;
        base = log_q.size();
        load_tile(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        chk("s1_valid_next", 32'(o_valid), 32'd1);
        wait_log(base + 4);
        chk_stream("s1_stream", base, 16'h0001, 16'h0003, 16'h0002, 16'h0004);
        tick();
        chk("s1_idle", 32'(o_valid), 32'd0);

        // 2: skewed arrival
        base = log_q.size();
        data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        vld  = 4'b0001; tick();
        chk("s2_busy_c1", 32'(o_busy), 32'd0);
        vld  = 4'b0110; tick();
        chk("s2_busy_c2", 32'(o_busy), 32'd0);
        vld  = 4'b1000; tick();
        vld  = 4'b0000;
        chk("s2_valid_c3", 32'(o_valid), 32'd1);
        wait_log(base + 4);
        chk_stream("s2_stream", base, 16'h0001, 16'h0003, 16'h0002, 16'h0004);
        tick();

        // 3: backpressure
        base = log_q.size();
        rdy  = 1'b0;
        load_tile(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        pat[4] = 1'b1; pat[5] = 1'b1; pat[6] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rdy = pat[i];
            tick();
        end
        chk("s3_count", 32'(log_q.size()), 32'(base + 4));
        chk_stream("s3_stream", base, 16'h0001, 16'h0003, 16'h0002, 16'h0004);
        rdy = 1'b1;
        tick();

        // 4a: result pulse during DRAIN
        base = log_q.size();
        load_tile(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        data[2*W +: W] = 16'hBEEF;
        vld = 4'b0100; tick();
        vld = 4'b0000;
        chk("s4a_ovf", 32'(o_ovf), 32'd1);
        wait_log(base + 4);
        chk_stream("s4a_stream", base, 16'h0001, 16'h0003, 16'h0002, 16'h0004);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("s4a_clr", 32'(o_ovf), 32'd0);

        // 4b: double pulse on k=0 during COLLECT
        base = log_q.size();
        data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        vld  = 4'b0001; tick();
        data[0 +: W] = 16'h0055;
        vld  = 4'b0001; tick();
        vld  = 4'b1110; tick();
        vld  = 4'b0000;
        chk("s4b_ovf", 32'(o_ovf), 32'd1);
        wait_log(base + 4);
        chk_stream("s4b_stream", base, 16'h0001, 16'h0003, 16'h0002, 16'h0004);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("s4b_clr", 32'(o_ovf), 32'd0);

        // 5: reset mid-drain
        base = log_q.size();
        load_tile(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        tick();
        tick();
        chk("s5_two_xfers", 32'(log_q.size()), 32'(base + 2));
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(o_valid), 32'd0);
        chk("s5_rst_busy", 32'(o_busy), 32'd0);
        chk("s5_rst_row", 32'(o_row), 32'd0);
        chk("s5_rst_col", 32'(o_col), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        base = log_q.size();
        load_tile(16'h0011, 16'h0012, 16'h0013, 16'h0014);
        chk("s5_row0", 32'(o_row), 32'd0);
        chk("s5_col0", 32'(o_col), 32'd0);
        wait_log(base + 4);
        chk_stream("s5_stream", base, 16'h0011, 16'h0013, 16'h0012, 16'h0014);
        tick();

        // 6: back-to-back tiles
        base = log_q.size();
        load_tile(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        tick(); tick(); tick();
        chk("s6_last", 32'(o_last), 32'd1);
        tick();
        load_tile(16'h0021, 16'h0022, 16'h0023, 16'h0024);
        chk("s6_ovf", 32'(o_ovf), 32'd0);
        chk("s6_valid", 32'(o_valid), 32'd1);
        wait_log(base + 8);
        chk_stream("s6_tile_a", base, 16'h0001, 16'h0003, 16'h0002, 16'h0004);
        chk_stream("s6_tile_b", base + 4, 16'h0021, 16'h0023, 16'h0022, 16'h0024);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
